// File: rtl/data_memory_ctrl.sv
// Memory-stage data memory controller: word RAM with configurable latency, stall and fault generation.
// Optional MMIO (LED register, free-running cycle counter) is enabled with `define DMEM_MMIO_EN.
module data_memory_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWriteM,
  input  logic             MemToRegM,
  input  logic [31:0]      ALUOutM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             FaultM,
  output logic [7:0]       Leds
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, nextState;
  logic [CW-1:0]        cnt, nextCnt;
  logic                 req, aligned, inRange, isLeds, isCycle, isMmio, legal, commit;
  logic [ADDR_BITS-1:0] wordIdx;
  logic [WIDTH-1:0]     loadData;
  logic [WIDTH-1:0]     mem [2**ADDR_BITS];

  assign req     = MemWriteM | MemToRegM;
  assign wordIdx = ALUOutM[ADDR_BITS+1:2];
  assign aligned = (ALUOutM[1:0] == 2'b00);
  assign inRange = (ALUOutM[31:ADDR_BITS+2] == '0);

`ifdef DMEM_MMIO_EN
  logic [31:0] cycleCnt;

  assign isLeds  = (ALUOutM == 32'hFFFF_FF00);
  assign isCycle = (ALUOutM == 32'hFFFF_FF04);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycleCnt <= '0;
      Leds     <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (commit && MemWriteM && isLeds)
        Leds <= WriteDataM[7:0];
    end
  end

  always_comb begin
    loadData = mem[wordIdx];
    if (isLeds)
      loadData = WIDTH'(Leds);
    else if (isCycle)
      loadData = WIDTH'(cycleCnt);
  end
`else
  assign isLeds   = 1'b0;
  assign isCycle  = 1'b0;
  assign Leds     = '0;
  assign loadData = mem[wordIdx];
`endif

  assign isMmio = isLeds | isCycle;
  assign legal  = (aligned & inRange) | isMmio;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    StallM    = 1'b0;
    FaultM    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (legal) begin
            StallM    = 1'b1;
            nextState = BUSY;
            nextCnt   = isMmio ? '0 : CW'(LATENCY - 1);
          end else begin
            FaultM = 1'b1;
          end
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (cnt == '0) begin
          commit    = 1'b1;
          nextState = DONE;
        end else begin
          nextCnt = cnt - CW'(1);
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Reset on the commit edge must also suppress the RAM write, hence the explicit gate.
  always_ff @(posedge clk) begin
    if (!reset && commit && MemWriteM && !isMmio)
      mem[wordIdx] <= WriteDataM;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ReadDataM <= '0;
    else if (commit && MemToRegM && !MemWriteM)
      ReadDataM <= loadData;
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed cases plus randomized accesses against a word-array model.
module tb_data_memory_ctrl;

  localparam int W   = 32;
  localparam int AB  = 10;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWriteM, MemToRegM;
  logic [31:0]   ALUOutM;
  logic [W-1:0]  WriteDataM;
  logic [W-1:0]  ReadDataM;
  logic          StallM, FaultM;
  logic [7:0]    Leds;

  data_memory_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .FaultM(FaultM), .Leds(Leds)
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] refMem [int unsigned];
  logic [31:0] expRead;
  logic [7:0]  expLeds;
  bit          readKnown;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit isMmioAddr(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return (a == 32'hFFFF_FF00) || (a == 32'hFFFF_FF04);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legalAddr(input logic [31:0] a);
    return ((a % 4) == 0 && (a >> (AB + 2)) == 0) || isMmioAddr(a);
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata);
    int unsigned idx;
    int stalls;
    bit mmio;
    @(posedge clk); #1;
    MemWriteM = wr; MemToRegM = rd; ALUOutM = addr; WriteDataM = data;
    @(negedge clk);
    if (!legalAddr(addr)) begin
      check("fault", FaultM, 1);
      check("faultNoStall", StallM, 0);
      if (readKnown) check("faultReadHeld", ReadDataM, expRead);
      check("faultLedsHeld", Leds, expLeds);
    end else begin
      mmio   = isMmioAddr(addr);
      idx    = (addr / 4) % (2 ** AB);
      stalls = 0;
      check("noFault", FaultM, 0);
      while (StallM && stalls < 64) begin
        stalls++;
        @(negedge clk);
      end
      check("stallCycles", stalls, mmio ? 2 : LAT + 1);
      if (wr) begin
        if (addr == 32'hFFFF_FF00 && mmio) expLeds = data[7:0];
        else if (!mmio) refMem[idx] = data;
      end else if (rd) begin
        if (addr == 32'hFFFF_FF00 && mmio) begin
          expRead = {24'b0, expLeds}; readKnown = 1;
        end else if (!mmio && refMem.exists(idx)) begin
          expRead = refMem[idx]; readKnown = 1;
        end else begin
          readKnown = 0;
        end
      end
      if (readKnown) check("readData", ReadDataM, expRead);
      check("leds", Leds, expLeds);
    end
    rdata = ReadDataM;
    @(posedge clk); #1;
    MemWriteM = 0; MemToRegM = 0;
  endtask

  // Starts a store, asserts reset during cycle T+resetCycle, then checks the aftermath.
  task automatic resetDuringStore(input logic [31:0] addr, input logic [31:0] data, input int resetCycle);
    @(posedge clk); #1;
    MemWriteM = 1; MemToRegM = 0; ALUOutM = addr; WriteDataM = data;
    repeat (resetCycle) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0; MemWriteM = 0;
    expRead = '0; expLeds = '0; readKnown = 1;
    @(negedge clk);
    check("resetStall", StallM, 0);
    check("resetRead", ReadDataM, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r1, r2, a;
    int unsigned k, idx;
    reset = 1; MemWriteM = 0; MemToRegM = 0; ALUOutM = '0; WriteDataM = '0;
    expRead = '0; expLeds = '0; readKnown = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rstRead", ReadDataM, 0);
    check("rstStall", StallM, 0);
    check("rstFault", FaultM, 0);
    check("rstLeds", Leds, 0);

    access(1, 0, 32'h10, 32'hDEADBEEF, r);
    access(0, 1, 32'h10, 32'h0, r);
    access(0, 1, 32'h13, 32'h0, r);
    access(0, 1, 32'h10, 32'h0, r);
    check("reloadAfterFault", r, 32'hDEADBEEF);

    access(1, 0, 32'h0, 32'h11112222, r);
    access(1, 0, 32'h1000, 32'h0BAD0BAD, r);
    access(0, 1, 32'h0, 32'h0, r);
    check("word0Intact", r, 32'h11112222);

    access(1, 0, 32'h20, 32'hCAFE0020, r);
    resetDuringStore(32'h20, 32'h1234, 2);
    access(0, 1, 32'h20, 32'h0, r);
    check("midStoreDropped", r, 32'hCAFE0020);
    resetDuringStore(32'h20, 32'h5678, LAT);
    access(0, 1, 32'h20, 32'h0, r);
    check("commitEdgeDropped", r, 32'hCAFE0020);

    access(1, 1, 32'h40, 32'h5A5A, r);
    access(0, 1, 32'h40, 32'h0, r);
    check("bothLinesStore", r, 32'h5A5A);

`ifdef DMEM_MMIO_EN
    access(1, 0, 32'hFFFF_FF00, 32'hA5, r);
    access(1, 0, 32'hFFFF_FF04, 32'h77, r);
    access(0, 1, 32'hFFFF_FF00, 32'h0, r);
    check("ledsReadback", r, 32'hA5);
    access(0, 1, 32'hFFFF_FF04, 32'h0, r1);
    repeat (6) @(posedge clk);
    access(0, 1, 32'hFFFF_FF04, 32'h0, r2);
    check("cycleDelta", r2 - r1, 10);
    access(0, 1, 32'h40, 32'h0, r);
`else
    access(1, 0, 32'hFFFF_FF00, 32'hA5, r);
    check("noMmioLeds", Leds, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      k   = $urandom_range(0, 5);
      idx = $urandom_range(0, 63);
      a   = idx * 4;
      case (k)
        0, 1: access(1, 0, a, $urandom(), r);
        2:    if (refMem.exists(idx)) access(0, 1, a, 0, r);
              else access(1, 0, a, $urandom(), r);
        3:    access($urandom_range(0, 1) == 1, 1, a | $urandom_range(1, 3), $urandom(), r);
        4:    access($urandom_range(0, 1) == 1, 1, ($urandom() | 32'h0000_1000) & 32'h7FFF_FFFC, $urandom(), r);
        default: access(1, 1, a, $urandom(), r);
      endcase
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Memory-stage data memory controller for the 5-stage pipelined core. It sits directly downstream of the execute/memory pipeline register and takes the place of the single-cycle data memory. It contains a word-addressed RAM with a configurable access latency and sequences loads and stores through a small FSM. While an access is in flight it asserts a stall so the hazard logic freezes the pipeline, and it flags illegal addresses.

## Interface
Parameters:
- WIDTH, 32, data word width.
- ADDR_BITS, 10, word-index width; the RAM holds 2^ADDR_BITS words.
- LATENCY, 3, RAM access cycles. Must be ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWriteM  input  1  store request from the M stage.
- MemToRegM  input  1  load request from the M stage.
- ALUOutM  input  32  byte address.
- WriteDataM  input  WIDTH  store data.
- ReadDataM  output  WIDTH  load result register.
- StallM  output  1  freeze request to the hazard unit.
- FaultM  output  1  illegal-address flag for the current M-stage request.
- Leds  output  8  MMIO LED register. Driven 0 when MMIO is compiled out.

## Operation
- Request condition: req = MemWriteM | MemToRegM.
- If both MemWriteM and MemToRegM are high, the request is a store only and ReadDataM is not updated.
- Word index = ALUOutM[ADDR_BITS+1:2].
- Illegal address: ALUOutM[1:0] != 0, or ALUOutM[31:ADDR_BITS+2] != 0, unless the address is a valid MMIO address.
- States:
  - IDLE: if req and the address is illegal, FaultM=1 combinationally and the FSM stays in IDLE. No access, no stall.
  - IDLE: if req and the address is legal, go to BUSY and load cnt=LATENCY-1 (cnt=0 for MMIO).
  - BUSY: while cnt != 0, decrement cnt.
  - BUSY: when cnt==0, go to DONE. On that edge a store writes the RAM/MMIO register, and a load captures RAM/MMIO data into ReadDataM.
  - DONE: go to IDLE unconditionally. The pipeline advances on the same edge, so the request is not re-triggered.
- StallM = (IDLE & req & legal) | BUSY. StallM is low in DONE.
- The M-stage inputs are guaranteed stable while StallM=1.
- ReadDataM holds its value except on load completion.
- RAM contents are not initialised and are not cleared by reset.

## Timing
- Reset values: state=IDLE, cnt=0, ReadDataM=0, Leds=0, StallM=0 and FaultM=0 (given req=0 during reset).
- Legal RAM access presented in cycle T:
  - StallM=1 in cycles T..T+LATENCY.
  - The commit edge is the end of cycle T+LATENCY.
  - DONE in cycle T+LATENCY+1 with StallM=0 and the load data valid on ReadDataM.
  - Total stall cycles = LATENCY+1.
- MMIO access: StallM=1 in cycles T and T+1, DONE in T+2.
- Illegal access: FaultM=1 in cycle T only, StallM=0, zero added cycles.
- Reset during BUSY: IDLE on the next cycle and StallM=0. A store whose commit edge had not occurred is dropped. A reset on the commit edge itself wins, and the store is dropped.
- Back-to-back accesses: a new request is only seen in IDLE, which gives one DONE cycle between accesses.

## Configuration
- DMEM_MMIO_EN:
  - When defined, 0xFFFF_FF00 is the LED register: a store writes Leds=WriteDataM[7:0] and a load returns it zero-extended.
  - When defined, 0xFFFF_FF04 is a read-only 32-bit free-running cycle counter. It resets to 0, increments every cycle, and wraps modulo 2^32. Stores to it are ignored without a fault.
  - Both MMIO addresses take the 1-cycle MMIO path.
  - When not defined, these addresses are illegal (FaultM), Leds is tied to 0, and no counter exists.

## Test plan
- Store then load (LATENCY=3): store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010. Each access gives 4 StallM cycles, and ReadDataM=0xDEADBEEF in the load's DONE cycle.
- Misaligned load 0x0000_0013 → FaultM=1 for one cycle, StallM=0, ReadDataM unchanged. A following load of 0x10 still returns 0xDEADBEEF.
- Out-of-range store to 0x0000_1000 (ADDR_BITS=10) → FaultM=1, no stall, and word 0 is unchanged on readback.
- Reset mid-store: store 0x1234 to 0x20 and assert reset in the second BUSY cycle → StallM=0 the next cycle. A later load of 0x20 returns the prior contents.
- Both request lines high: MemWriteM=MemToRegM=1, 0x5A5A to 0x40 → RAM updated and ReadDataM unchanged.
- MMIO with DMEM_MMIO_EN defined:
  - Store 0xA5 to 0xFFFF_FF00 → Leds=0xA5 after 2 stall cycles.
  - Two loads of 0xFFFF_FF04 started exactly 10 cycles apart → results differ by 10.
- MMIO without DMEM_MMIO_EN: store 0xA5 to 0xFFFF_FF00 → FaultM=1 and Leds=0.
